// File: rtl/ay_wr_arbiter.sv
// ay_wr_arbiter: shares the single ay3891x write port between the CPU I/O path
// and a {register, value} command queue. Queued writes are issued as atomic
// address/data pairs, and the CPU's latched address is restored afterwards.
module ay_wr_arbiter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_a0,
  input  logic                   cpu_wr_tick,
  input  logic [7:0]             cpu_wdata,
  input  logic                   q_valid,
  output logic                   q_ready,
  input  logic [3:0]             q_reg,
  input  logic [7:0]             q_data,
  output logic                   ay_a0,
  output logic                   ay_wr_tick,
  output logic [7:0]             ay_wdata,
  output logic [$clog2(DEPTH):0] q_level,
  output logic                   busy,
  output logic                   cpu_overrun
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam int unsigned    LW      = AW + 1;
  localparam logic [3:0]     GapLoad = 4'(GAP);
  localparam logic [LW-1:0]  Full    = LW'(DEPTH);

  // Tick states name the write currently on the output registers; ret holds
  // what must be issued once the gap expires.
  typedef enum logic [2:0] {
    StIdle, StCpuIssue, StQAddr, StQData, StRestore, StWait
  } state_e;

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;

  logic [11:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;

  logic          cpu_pend_q, cpu_pend_d;
  logic          hold_a0_q;
  logic [7:0]    hold_data_q;
  logic          overrun_q;

  logic [3:0]    chip_addr_q, chip_addr_d;
  logic [3:0]    cpu_addr_q, cpu_addr_d;
  logic [3:0]    gap_q, gap_d;

  logic          ay_a0_q, ay_a0_d;
  logic          ay_tick_q, ay_tick_d;
  logic [7:0]    ay_wdata_q, ay_wdata_d;

  logic          push, pop, cpu_take;
  logic          cpu_have, cpu_a0_eff;
  logic [7:0]    cpu_data_eff;
  logic [3:0]    head_reg;
  logic [7:0]    head_data;
  logic          do_cpu, do_qaddr, do_qdata, do_restore;

  // FIFO flags, head entry and CPU bypass so an idle arbiter issues in one clk
  always_comb begin
    q_ready      = (level_q != Full);
    push         = q_valid & q_ready;
    head_reg     = mem_q[rd_ptr_q][11:8];
    head_data    = mem_q[rd_ptr_q][7:0];
    cpu_have     = cpu_pend_q | cpu_wr_tick;
    cpu_a0_eff   = cpu_wr_tick ? cpu_a0 : hold_a0_q;
    cpu_data_eff = cpu_wr_tick ? cpu_wdata : hold_data_q;
  end

  // Issue selection and next-state: only evaluated once the gap counter is zero
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    ay_a0_d     = ay_a0_q;
    ay_wdata_d  = ay_wdata_q;
    ay_tick_d   = 1'b0;
    chip_addr_d = chip_addr_q;
    cpu_addr_d  = cpu_addr_q;
    pop         = 1'b0;
    cpu_take    = 1'b0;
    do_cpu      = 1'b0;
    do_qaddr    = 1'b0;
    do_qdata    = 1'b0;
    do_restore  = 1'b0;

    if (gap_q == 4'd0) begin
      case (ret_q)
        StQData:   do_qdata   = 1'b1;
        StRestore: do_restore = 1'b1;
        default: begin
          if (cpu_have) begin
            do_cpu = 1'b1;
          end else if (level_q != '0) begin
            if (head_reg == chip_addr_q) do_qdata = 1'b1;
            else                         do_qaddr = 1'b1;
          end
        end
      endcase
    end

    if (do_cpu) begin
      state_d    = StCpuIssue;
      ret_d      = StIdle;
      ay_tick_d  = 1'b1;
      ay_a0_d    = cpu_a0_eff;
      ay_wdata_d = cpu_data_eff;
      cpu_take   = 1'b1;
      if (!cpu_a0_eff) begin
        cpu_addr_d  = cpu_data_eff[3:0];
        chip_addr_d = cpu_data_eff[3:0];
      end
    end else if (do_qaddr) begin
      state_d     = StQAddr;
      ret_d       = StQData;
      ay_tick_d   = 1'b1;
      ay_a0_d     = 1'b0;
      ay_wdata_d  = {4'b0, head_reg};
      chip_addr_d = head_reg;
    end else if (do_qdata) begin
      state_d    = StQData;
      ret_d      = (head_reg != cpu_addr_q) ? StRestore : StIdle;
      ay_tick_d  = 1'b1;
      ay_a0_d    = 1'b1;
      ay_wdata_d = head_data;
      pop        = 1'b1;
    end else if (do_restore) begin
      state_d     = StRestore;
      ret_d       = StIdle;
      ay_tick_d   = 1'b1;
      ay_a0_d     = 1'b0;
      ay_wdata_d  = {4'b0, cpu_addr_q};
      chip_addr_d = cpu_addr_q;
    end else if (gap_q == 4'd0) begin
      state_d = StIdle;
      ret_d   = StIdle;
    end else begin
      state_d = StWait;
    end

    if (ay_tick_d)            gap_d = GapLoad;
    else if (gap_q != 4'd0)   gap_d = gap_q - 4'd1;
    else                      gap_d = 4'd0;

    if (cpu_take)         cpu_pend_d = 1'b0;
    else if (cpu_wr_tick) cpu_pend_d = 1'b1;
    else                  cpu_pend_d = cpu_pend_q;

    level_d = level_q + LW'(push) - LW'(pop);
  end

  // Control state, address tracking, CPU holding register and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ret_q       <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cpu_pend_q  <= 1'b0;
      hold_a0_q   <= 1'b0;
      hold_data_q <= 8'h00;
      overrun_q   <= 1'b0;
      chip_addr_q <= 4'd0;
      cpu_addr_q  <= 4'd0;
      gap_q       <= 4'd0;
      ay_a0_q     <= 1'b0;
      ay_tick_q   <= 1'b0;
      ay_wdata_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      level_q     <= level_d;
      cpu_pend_q  <= cpu_pend_d;
      chip_addr_q <= chip_addr_d;
      cpu_addr_q  <= cpu_addr_d;
      gap_q       <= gap_d;
      ay_a0_q     <= ay_a0_d;
      ay_tick_q   <= ay_tick_d;
      ay_wdata_q  <= ay_wdata_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (cpu_wr_tick) begin
        hold_a0_q   <= cpu_a0;
        hold_data_q <= cpu_wdata;
      end
      // A new CPU write landing on an unissued one loses the older write
      if (cpu_wr_tick && cpu_pend_q) overrun_q <= 1'b1;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by the pointers/level
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {q_reg, q_data};
  end

  // Output mapping
  always_comb begin
    ay_a0       = ay_a0_q;
    ay_wr_tick  = ay_tick_q;
    ay_wdata    = ay_wdata_q;
    q_level     = level_q;
    cpu_overrun = overrun_q;
    busy        = (state_q != StIdle) | cpu_pend_q | (level_q != '0);
  end

endmodule

// File: tb/tb_ay_wr_arbiter.sv
// Directed bench for ay_wr_arbiter (DEPTH=8, GAP=2).
module tb_ay_wr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_a0 = 1'b0;
  logic       cpu_wr_tick = 1'b0;
  logic [7:0] cpu_wdata = 8'h00;
  logic       q_valid = 1'b0;
  logic       q_ready;
  logic [3:0] q_reg = 4'h0;
  logic [7:0] q_data = 8'h00;
  logic       ay_a0;
  logic       ay_wr_tick;
  logic [7:0] ay_wdata;
  logic [3:0] q_level;
  logic       busy;
  logic       cpu_overrun;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int         log_c[$];
  logic       log_a[$];
  logic [7:0] log_d[$];

  ay_wr_arbiter #(.DEPTH(8), .GAP(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_a0      (cpu_a0),
    .cpu_wr_tick (cpu_wr_tick),
    .cpu_wdata   (cpu_wdata),
    .q_valid     (q_valid),
    .q_ready     (q_ready),
    .q_reg       (q_reg),
    .q_data      (q_data),
    .ay_a0       (ay_a0),
    .ay_wr_tick  (ay_wr_tick),
    .ay_wdata    (ay_wdata),
    .q_level     (q_level),
    .busy        (busy),
    .cpu_overrun (cpu_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every chip write with the cycle it was visible in
  always @(negedge clk) begin
    if (ay_wr_tick === 1'b1) begin
      log_c.push_back(cyc);
      log_a.push_back(ay_a0);
      log_d.push_back(ay_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_c.delete();
    log_a.delete();
    log_d.delete();
  endtask

  task automatic cpu_write(input logic a0, input logic [7:0] d, output int c);
    c = cyc;
    cpu_a0 = a0;
    cpu_wdata = d;
    cpu_wr_tick = 1'b1;
    step();
    cpu_wr_tick = 1'b0;
  endtask

  task automatic q_push(input logic [3:0] r, input logic [7:0] d, output int c);
    c = cyc;
    q_reg = r;
    q_data = d;
    q_valid = 1'b1;
    step();
    q_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_timeout: busy=%0b after %0d cycles, expected 0", name, busy, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_chk++; if (q_ready !== 1'b1)     begin n_fail++; $display("FAIL reset q_ready: got %0b exp 1", q_ready); end
    n_chk++; if (ay_wr_tick !== 1'b0)  begin n_fail++; $display("FAIL reset ay_wr_tick: got %0b exp 0", ay_wr_tick); end
    n_chk++; if (ay_a0 !== 1'b0)       begin n_fail++; $display("FAIL reset ay_a0: got %0b exp 0", ay_a0); end
    n_chk++; if (ay_wdata !== 8'h00)   begin n_fail++; $display("FAIL reset ay_wdata: got %02h exp 00", ay_wdata); end
    n_chk++; if (q_level !== 4'd0)     begin n_fail++; $display("FAIL reset q_level: got %0d exp 0", q_level); end
    n_chk++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset busy: got %0b exp 0", busy); end
    n_chk++; if (cpu_overrun !== 1'b0) begin n_fail++; $display("FAIL reset cpu_overrun: got %0b exp 0", cpu_overrun); end
    reset = 1'b0;
    step();
  endtask

  // Plain CPU address + data write: one-clk latency, no restore
  task automatic test_cpu_write();
    int n, m;
    clear_log();
    cpu_write(1'b0, 8'h07, n);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cpu_write busy: got %0b exp 1", busy); end
    wait_idle("cpu_write_a", 50);
    cpu_write(1'b1, 8'h38, m);
    wait_idle("cpu_write_b", 50);
    n_chk++;
    if (log_c.size() !== 2) begin
      n_fail++; $display("FAIL cpu_write count: got %0d ticks exp 2", log_c.size());
    end
    n_chk++;
    if (log_c[0] !== n + 1 || log_a[0] !== 1'b0 || log_d[0] !== 8'h07) begin
      n_fail++;
      $display("FAIL cpu_write tick0: got cyc %0d a0 %0b d %02h exp cyc %0d a0 0 d 07",
               log_c[0], log_a[0], log_d[0], n + 1);
    end
    n_chk++;
    if (log_c[1] !== m + 1 || log_a[1] !== 1'b1 || log_d[1] !== 8'h38) begin
      n_fail++;
      $display("FAIL cpu_write tick1: got cyc %0d a0 %0b d %02h exp cyc %0d a0 1 d 38",
               log_c[1], log_a[1], log_d[1], m + 1);
    end
  endtask

  // Queued write to a different register: addr, data, restore spaced by 3
  task automatic test_queue_restore();
    int p;
    int ec[3];
    logic ea[3];
    logic [7:0] ed[3];
    clear_log();
    q_push(4'd0, 8'h55, p);
    n_chk++; if (q_level !== 4'd1) begin n_fail++; $display("FAIL q_restore level_after_push: got %0d exp 1", q_level); end
    wait_idle("q_restore", 60);
    n_chk++; if (q_level !== 4'd0) begin n_fail++; $display("FAIL q_restore level_end: got %0d exp 0", q_level); end
    ec = '{p + 2, p + 5, p + 8};
    ea = '{1'b0, 1'b1, 1'b0};
    ed = '{8'h00, 8'h55, 8'h07};
    n_chk++;
    if (log_c.size() !== 3) begin
      n_fail++; $display("FAIL q_restore count: got %0d ticks exp 3", log_c.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (log_c[i] !== ec[i] || log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
        n_fail++;
        $display("FAIL q_restore tick%0d: got cyc %0d a0 %0b d %02h exp cyc %0d a0 %0b d %02h",
                 i, log_c[i], log_a[i], log_d[i], ec[i], ea[i], ed[i]);
      end
    end
  endtask

  // Head register already latched: single data tick, no address, no restore
  task automatic test_direct_data();
    int c, p;
    cpu_write(1'b0, 8'h00, c);
    wait_idle("direct_setup", 50);
    clear_log();
    q_push(4'd0, 8'hAA, p);
    wait_idle("direct", 50);
    n_chk++;
    if (log_c.size() !== 1) begin
      n_fail++; $display("FAIL direct count: got %0d ticks exp 1", log_c.size());
    end
    n_chk++;
    if (log_c[0] !== p + 2 || log_a[0] !== 1'b1 || log_d[0] !== 8'hAA) begin
      n_fail++;
      $display("FAIL direct tick0: got cyc %0d a0 %0b d %02h exp cyc %0d a0 1 d AA",
               log_c[0], log_a[0], log_d[0], p + 2);
    end
  endtask

  // CPU write during an atomic queue sequence, then a CPU overrun
  task automatic test_cpu_preempt();
    int p, c, n;
    int ec[4];
    logic ea[4];
    logic [7:0] ed[4];
    clear_log();
    q_push(4'd5, 8'h66, p);
    step();
    step();
    cpu_write(1'b1, 8'h99, c);
    wait_idle("preempt", 60);
    ec = '{p + 2, p + 5, p + 8, p + 11};
    ea = '{1'b0, 1'b1, 1'b0, 1'b1};
    ed = '{8'h05, 8'h66, 8'h00, 8'h99};
    n_chk++;
    if (log_c.size() !== 4) begin
      n_fail++; $display("FAIL preempt count: got %0d ticks exp 4", log_c.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (log_c[i] !== ec[i] || log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
        n_fail++;
        $display("FAIL preempt tick%0d: got cyc %0d a0 %0b d %02h exp cyc %0d a0 %0b d %02h",
                 i, log_c[i], log_a[i], log_d[i], ec[i], ea[i], ed[i]);
      end
    end
    // 0x11 issues at once; 0x22 and 0x33 both land before the gap expires
    clear_log();
    cpu_write(1'b1, 8'h11, n);
    cpu_write(1'b1, 8'h22, c);
    n_chk++; if (cpu_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun early: got %0b exp 0", cpu_overrun); end
    cpu_write(1'b1, 8'h33, c);
    n_chk++; if (cpu_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun set: got %0b exp 1", cpu_overrun); end
    wait_idle("overrun", 50);
    n_chk++;
    if (log_c.size() !== 2 || log_d[0] !== 8'h11 || log_d[1] !== 8'h33 || log_c[1] !== n + 4) begin
      n_fail++;
      $display("FAIL overrun ticks: got n=%0d d0 %02h d1 %02h cyc1 %0d exp n=2 d0 11 d1 33 cyc1 %0d",
               log_c.size(), log_d[0], log_d[1], log_c[1], n + 4);
    end
  endtask

  // Fill the FIFO while CPU traffic starves the queue, then drain in order
  task automatic test_fifo_full();
    int k;
    clear_log();
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (q_ready !== (i < 8) || q_level !== 4'(i)) begin
        n_fail++;
        $display("FAIL full push%0d: got q_ready %0b level %0d exp q_ready %0b level %0d",
                 i, q_ready, q_level, (i < 8), i);
      end
      q_valid = 1'b1;
      q_reg = 4'd0;
      q_data = 8'h10 + 8'(i);
      cpu_a0 = 1'b1;
      cpu_wdata = 8'hEE;
      cpu_wr_tick = 1'b1;
      step();
    end
    q_valid = 1'b0;
    cpu_wr_tick = 1'b0;
    n_chk++; if (q_level !== 4'd8) begin n_fail++; $display("FAIL full level_after: got %0d exp 8", q_level); end
    wait_idle("full_drain", 300);
    k = 0;
    for (int i = 0; i < log_d.size(); i++) begin
      if (log_d[i] !== 8'hEE) begin
        n_chk++;
        if (log_d[i] !== 8'h10 + 8'(k) || log_a[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL full drain%0d: got a0 %0b d %02h exp a0 1 d %02h",
                   k, log_a[i], log_d[i], 8'h10 + 8'(k));
        end
        k++;
      end
    end
    n_chk++; if (k !== 8) begin n_fail++; $display("FAIL full drain_count: got %0d exp 8", k); end
  endtask

  // Reset during Q_DATA's wait discards everything and stops issuing
  task automatic test_reset_midop();
    int p;
    clear_log();
    p = cyc;
    for (int i = 0; i < 4; i++) begin
      q_valid = 1'b1;
      q_reg = 4'd3;
      q_data = 8'h30 + 8'(i);
      step();
    end
    q_valid = 1'b0;
    step();
    step();
    n_chk++; if (q_level !== 4'd3) begin n_fail++; $display("FAIL midrst level_before: got %0d exp 3", q_level); end
    reset = 1'b1;
    step();
    n_chk++;
    if (q_level !== 4'd0 || q_ready !== 1'b1 || busy !== 1'b0 || ay_wr_tick !== 1'b0 ||
        cpu_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst state: got level %0d rdy %0b busy %0b tick %0b ovr %0b exp 0 1 0 0 0",
               q_level, q_ready, busy, ay_wr_tick, cpu_overrun);
    end
    reset = 1'b0;
    repeat (12) step();
    n_chk++;
    if (log_c.size() !== 2 || log_c[0] !== p + 2 || log_c[1] !== p + 5) begin
      n_fail++;
      $display("FAIL midrst ticks: got n=%0d c0 %0d c1 %0d exp n=2 c0 %0d c1 %0d",
               log_c.size(), log_c[0], log_c[1], p + 2, p + 5);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_queue_restore();
    test_direct_data();
    test_cpu_preempt();
    test_fifo_full();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
